// File: rtl/defs_vga.sv
// Package defs_vga: default VGA timing constants, colour channel widths and the
// derived totals. Both vga_axis_cnt and vga_timing_gen default their parameters
// to these values.
package defs_vga;

    // 640x480 @ 60 Hz, pixel timing in pixels / lines.
    localparam int DEF_H_ACTIVE  = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_ACTIVE  = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    // Asserted sync level: 0 = active-low.
    localparam int DEF_HSYNC_POL = 0;
    localparam int DEF_VSYNC_POL = 0;

    // System clocks per pixel.
    localparam int DEF_CLK_DIV   = 2;

    // RGB565 colour packing.
    localparam int DEF_BITS_R    = 5;
    localparam int DEF_BITS_G    = 6;
    localparam int DEF_BITS_B    = 5;

    // Length of one axis (line or frame) in pixel slots / lines.
    function automatic int axis_total(input int active, input int front,
                                      input int sync, input int back);
        return active + front + sync + back;
    endfunction

    localparam int DEF_H_TOTAL    = axis_total(DEF_H_ACTIVE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
    localparam int DEF_V_TOTAL    = axis_total(DEF_V_ACTIVE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);
    localparam int DEF_TOTAL_BITS = DEF_BITS_R + DEF_BITS_G + DEF_BITS_B;

endpackage

// File: rtl/vga_axis_cnt.sv
// vga_axis_cnt: one timing axis (horizontal or vertical). A counter that
// wraps from TOTAL-1 to 0, with decode of the active region and of the sync
// pulse.
//
// Ports
//   clk, rst_n  clock, asynchronous active-low reset
//   clr_i       synchronous clear to 0 (takes priority over adv_i)
//   adv_i       advance the counter by one position
//   cnt_o       current position, 0..TOTAL-1
//   wrap_o      adv_i while at TOTAL-1, so the next position is 0
//   active_o    cnt_o < ACTIVE
//   sync_o      sync level for cnt_o: POL inside the sync window, !POL outside
module vga_axis_cnt
    import defs_vga::*;
#(
    parameter  int ACTIVE = DEF_H_ACTIVE,
    parameter  int FRONT  = DEF_H_FRONT,
    parameter  int SYNC   = DEF_H_SYNC,
    parameter  int BACK   = DEF_H_BACK,
    parameter  int POL    = DEF_HSYNC_POL,
    localparam int TOTAL  = axis_total(ACTIVE, FRONT, SYNC, BACK),
    localparam int W      = $clog2(TOTAL)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         adv_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o,
    output logic         active_o,
    output logic         sync_o
);

    if (ACTIVE < 1 || FRONT < 1 || SYNC < 1 || BACK < 1) begin : g_bad_param
        $error("vga_axis_cnt: timing parameters must all be at least 1");
    end

    localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT_END  = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_LO  = W'(ACTIVE + FRONT);
    // BACK >= 1, so the end of the sync window is still below TOTAL and fits in W bits.
    localparam logic [W-1:0] SYNC_HI  = W'(ACTIVE + FRONT + SYNC);
    localparam logic         SYNC_LVL = (POL != 0);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (adv_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign wrap_o   = adv_i && (cnt_q == LAST);
    assign active_o = (cnt_q < ACT_END);
    assign sync_o   = ((cnt_q >= SYNC_LO) && (cnt_q < SYNC_HI)) ? SYNC_LVL : ~SYNC_LVL;

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster timing generator with a pixel-request interface.
// A clock divider makes one pixel tick every CLK_DIV clocks. The horizontal
// and vertical counters walk the raster on those ticks.
//
// req_valid/req_x/req_y are combinational from the counters. They name the
// pixel wanted in the current pixel slot. There is no ready: the source must
// present pix_in for (req_x, req_y) before the tick that ends the slot,
// because pix_in is sampled only on that tick. When req_valid is low, pix_in
// is ignored.
//
// hsync/vsync/rgb are registered on the tick, so they lag req_x/req_y by
// exactly one pixel slot. Colour and sync therefore stay aligned.
// line_start/frame_start pulse for one clock. They mark the first output
// slot of a line or frame, and so they are aligned with that registered
// output.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   en                       run enable; low clears the counters and idles the outputs
//   req_valid, req_x, req_y  pixel request for the current slot
//   pix_in                   packed {R,G,B} colour for the requested pixel
//   hsync, vsync             registered sync outputs
//   vga_r, vga_g, vga_b      registered colour, zero outside the active area
//   line_start, frame_start  one-clock start-of-line / start-of-frame pulses
module vga_timing_gen
    import defs_vga::*;
#(
    parameter  int H_ACTIVE   = DEF_H_ACTIVE,
    parameter  int H_FRONT    = DEF_H_FRONT,
    parameter  int H_SYNC     = DEF_H_SYNC,
    parameter  int H_BACK     = DEF_H_BACK,
    parameter  int V_ACTIVE   = DEF_V_ACTIVE,
    parameter  int V_FRONT    = DEF_V_FRONT,
    parameter  int V_SYNC     = DEF_V_SYNC,
    parameter  int V_BACK     = DEF_V_BACK,
    parameter  int HSYNC_POL  = DEF_HSYNC_POL,
    parameter  int VSYNC_POL  = DEF_VSYNC_POL,
    parameter  int CLK_DIV    = DEF_CLK_DIV,
    parameter  int BITS_R     = DEF_BITS_R,
    parameter  int BITS_G     = DEF_BITS_G,
    parameter  int BITS_B     = DEF_BITS_B,
    localparam int H_TOTAL    = axis_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK),
    localparam int V_TOTAL    = axis_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK),
    localparam int TOTAL_BITS = BITS_R + BITS_G + BITS_B,
    localparam int XW         = $clog2(H_TOTAL),
    localparam int YW         = $clog2(V_TOTAL)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    output logic                  req_valid,
    output logic [XW-1:0]         req_x,
    output logic [YW-1:0]         req_y,
    input  logic [TOTAL_BITS-1:0] pix_in,
    output logic                  hsync,
    output logic                  vsync,
    output logic [BITS_R-1:0]     vga_r,
    output logic [BITS_G-1:0]     vga_g,
    output logic [BITS_B-1:0]     vga_b,
    output logic                  line_start,
    output logic                  frame_start
);

    if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
        V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
        CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_param
        $error("vga_timing_gen: timing parameter is 0 or CLK_DIV outside 1..16");
    end

    // Sync outputs sit at the deasserted level while idle and in reset.
    localparam logic HS_IDLE = (HSYNC_POL == 0);
    localparam logic VS_IDLE = (VSYNC_POL == 0);

    // Divider: 4 bits cover CLK_DIV up to 16.
    localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);

    logic [3:0] div_q;
    logic [3:0] div_d;
    logic       tick;

    // en is part of tick, so an edge on which en is low never advances anything.
    assign tick = en && (div_q == DIV_LAST);

    always_comb begin
        div_d = div_q;
        if (!en || tick) begin
            div_d = '0;
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // Raster counters.
    logic [XW-1:0] h_cnt;
    logic [YW-1:0] v_cnt;
    logic          h_wrap;
    logic          h_active;
    logic          h_sync_lvl;
    logic          v_wrap_unused;
    logic          v_active;
    logic          v_sync_lvl;

    vga_axis_cnt #(
        .ACTIVE (H_ACTIVE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK),
        .POL    (HSYNC_POL)
    ) u_h_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (!en),
        .adv_i    (tick),
        .cnt_o    (h_cnt),
        .wrap_o   (h_wrap),
        .active_o (h_active),
        .sync_o   (h_sync_lvl)
    );

    // The line counter steps only on the tick where the pixel counter wraps.
    vga_axis_cnt #(
        .ACTIVE (V_ACTIVE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK),
        .POL    (VSYNC_POL)
    ) u_v_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (!en),
        .adv_i    (h_wrap),
        .cnt_o    (v_cnt),
        .wrap_o   (v_wrap_unused),
        .active_o (v_active),
        .sync_o   (v_sync_lvl)
    );

    assign req_valid = h_active && v_active;
    assign req_x     = h_cnt;
    assign req_y     = v_cnt;

    // Output pipeline stage: one pixel slot behind the request.
    logic              hsync_q, hsync_d;
    logic              vsync_q, vsync_d;
    logic [BITS_R-1:0] r_q, r_d;
    logic [BITS_G-1:0] g_q, g_d;
    logic [BITS_B-1:0] b_q, b_d;
    logic              ls_q, ls_d;
    logic              fs_q, fs_d;

    always_comb begin
        hsync_d = hsync_q;
        vsync_d = vsync_q;
        r_d     = r_q;
        g_d     = g_q;
        b_d     = b_q;
        ls_d    = 1'b0;
        fs_d    = 1'b0;
        if (!en) begin
            hsync_d = HS_IDLE;
            vsync_d = VS_IDLE;
            r_d     = '0;
            g_d     = '0;
            b_d     = '0;
        end else if (tick) begin
            hsync_d = h_sync_lvl;
            vsync_d = v_sync_lvl;
            if (req_valid) begin
                r_d = pix_in[TOTAL_BITS-1 -: BITS_R];
                g_d = pix_in[BITS_G+BITS_B-1 -: BITS_G];
                b_d = pix_in[BITS_B-1:0];
            end else begin
                r_d = '0;
                g_d = '0;
                b_d = '0;
            end
            ls_d = (h_cnt == '0);
            fs_d = (h_cnt == '0) && (v_cnt == '0);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q <= HS_IDLE;
            vsync_q <= VS_IDLE;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
        end
    end

    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign vga_r       = r_q;
    assign vga_g       = g_q;
    assign vga_b       = b_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a small raster (H 8/2/2/2, V 4/1/1/1) with a
// divider of 3 and active-high hsync. The reference model counts enabled
// clock edges. It derives the tick, the pixel position and the expected
// outputs from that count with plain arithmetic.
module tb_vga_timing_gen;

    localparam int HA = 8, HF = 2, HS = 2, HB = 2;
    localparam int VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int DIV = 3;
    localparam int HPOL = 1, VPOL = 0;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int XW = $clog2(HT);
    localparam int YW = $clog2(VT);
    localparam int OW = 20;
    localparam logic HS_ON = (HPOL != 0);
    localparam logic VS_ON = (VPOL != 0);

    // ---------------- clock / reset ----------------
    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          en    = 1'b0;
    logic [15:0]   pix_in = '0;
    logic          req_valid;
    logic [XW-1:0] req_x;
    logic [YW-1:0] req_y;
    logic          hsync, vsync, line_start, frame_start;
    logic [4:0]    vga_r;
    logic [5:0]    vga_g;
    logic [4:0]    vga_b;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE (HA), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_ACTIVE (VA), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
        .HSYNC_POL (HPOL), .VSYNC_POL (VPOL), .CLK_DIV (DIV),
        .BITS_R (5), .BITS_G (6), .BITS_B (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .req_valid   (req_valid),
        .req_x       (req_x),
        .req_y       (req_y),
        .pix_in      (pix_in),
        .hsync       (hsync),
        .vsync       (vsync),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .line_start  (line_start),
        .frame_start (frame_start)
    );

    // ---------------- reference model ----------------
    logic [OW-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;

    int         m_e  = 0;       // enabled edges since the last restart
    logic       m_hs = ~HS_ON;
    logic       m_vs = ~VS_ON;
    logic [15:0] m_rgb = '0;

    task automatic model_restart();
        m_e   = 0;
        m_hs  = ~HS_ON;
        m_vs  = ~VS_ON;
        m_rgb = '0;
    endtask

    // Expected registered outputs after the coming clock edge.
    task automatic model_edge();
        int   t, h, v;
        logic ls, fs;
        ls = 1'b0;
        fs = 1'b0;
        if (!en) begin
            model_restart();
        end else begin
            if ((m_e % DIV) == DIV - 1) begin
                t     = m_e / DIV;
                h     = t % HT;
                v     = (t / HT) % VT;
                m_hs  = (h >= HA + HF && h < HA + HF + HS) ? HS_ON : ~HS_ON;
                m_vs  = (v >= VA + VF && v < VA + VF + VS) ? VS_ON : ~VS_ON;
                m_rgb = (h < HA && v < VA) ? pix_in : 16'h0000;
                ls    = (h == 0);
                fs    = (h == 0) && (v == 0);
            end
            m_e++;
        end
        exp_q.push_back({m_hs, m_vs, m_rgb, ls, fs});
    endtask

    // ---------------- driver tasks ----------------
    task automatic check_comb();
        int   t, h, v;
        logic ev;
        t  = m_e / DIV;
        h  = t % HT;
        v  = (t / HT) % VT;
        ev = (h < HA) && (v < VA);
        checks++;
        if (req_x !== XW'(h) || req_y !== YW'(v) || req_valid !== ev) begin
            errors++;
            $display("FAIL req t=%0t: actual x=%0d y=%0d valid=%b, required x=%0d y=%0d valid=%b",
                     $time, req_x, req_y, req_valid, h, v, ev);
        end
    endtask

    task automatic check_reset(input string name);
        logic [OW+XW+YW-1:0] act, req;
        act = {hsync, vsync, vga_r, vga_g, vga_b, line_start, frame_start, req_x, req_y};
        req = {~HS_ON, ~VS_ON, 16'h0000, 1'b0, 1'b0, {XW{1'b0}}, {YW{1'b0}}};
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s t=%0t: actual %h, required %h", name, $time, act, req);
        end
    endtask

    task automatic step(input logic en_v, input logic [15:0] pix_v);
        @(negedge clk);
        check_comb();
        en     = en_v;
        pix_in = pix_v;
        model_edge();
    endtask

    function automatic logic [15:0] pick_pix();
        return ($urandom_range(0, 3) == 0) ? 16'hF81F : 16'($urandom);
    endfunction

    // Reset asserted and released between clock edges.
    task automatic async_reset_pulse();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_reset("async_reset");
        repeat (2) @(posedge clk);
        #2;
        check_reset("reset_hold");
        #1;
        model_restart();
        rst_n = 1'b1;
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin : monitor
        logic [OW-1:0] e, a;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard t=%0t: no expected entry queued", $time);
                end else begin
                    e = exp_q.pop_front();
                    a = {hsync, vsync, vga_r, vga_g, vga_b, line_start, frame_start};
                    if (a !== e) begin
                        errors++;
                        $display("FAIL outputs t=%0t: actual hs=%b vs=%b rgb=%h ls=%b fs=%b, required hs=%b vs=%b rgb=%h ls=%b fs=%b",
                                 $time, a[19], a[18], a[17:2], a[1], a[0],
                                 e[19], e[18], e[17:2], e[1], e[0]);
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin : stimulus
        int low_left;
        low_left = 0;

        repeat (3) @(posedge clk);
        #1;
        check_reset("reset_state");
        #2;
        rst_n = 1'b1;

        repeat (4) step(1'b0, pick_pix());

        // Two and a half frames of uninterrupted running.
        for (int i = 0; i < 750; i++) step(1'b1, pick_pix());

        // Random short enable drops anywhere in the frame.
        for (int i = 0; i < 1500; i++) begin
            if (low_left == 0 && $urandom_range(0, 99) < 2) low_left = $urandom_range(1, 6);
            if (low_left > 0) begin
                step(1'b0, pick_pix());
                low_left--;
            end else begin
                step(1'b1, pick_pix());
            end
        end

        // Asynchronous reset mid-line, then one more full frame.
        for (int i = 0; i < 50; i++) step(1'b1, pick_pix());
        async_reset_pulse();
        for (int i = 0; i < 320; i++) step(1'b1, 16'hF81F);

        @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: actual %0d entries left, required 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
